uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  Serial receive core directly downstream of the idle-high 2-FF input synchronizer.
//  Consumes the synchronized line and detects the start bit (falling edge).
//  Samples each bit at mid-period, checks the stop bit, presents one received byte.
//  Reports overrun and framing errors to the register/host side.
// PARAMETERS
//  CLKS_PER_BIT  10  clk cycles per serial bit; >=4 and even
//  DATA_BITS     8   data bits per frame, LSB first
// PORTS
//  clk            in   1          system clock
//  n_rst          in   1          asynchronous, active-low reset
//  serial_in      in   1          synchronized line from synchronizer; idle 1
//  data_read      in   1          host pulse: byte consumed
//  rx_data        out  DATA_BITS  last good byte
//  data_ready     out  1          rx_data valid and unread
//  overrun_error  out  1          good byte arrived while data_ready was still set
//  framing_error  out  1          last frame's stop bit sampled 0
//  parity_error   out  1          only when UART_RX_PARITY_EN is defined
// BEHAVIOUR
//  Reset: all outputs 0, rx_data 0, state IDLE, edge register 1, counters 0.
//  Edge detect: prev_q <= serial_in. start_edge = prev_q & ~serial_in.
//  FSM states IDLE, START, DATA, [PARITY], STOP, LOAD. Cycle 0 = edge where start_edge=1.
//   IDLE:   start_edge -> START; clear cnt and bit_idx; clear framing_error.
//   START:  at cnt==CLKS_PER_BIT/2-1 (cycle 5 for default), sample serial_in.
//           Sample 0 -> DATA, cnt=0. Sample 1 -> glitch, back to IDLE, no flags.
//   DATA:   every CLKS_PER_BIT cycles, shift serial_in into MSB of shift_q (LSB-first).
//           After DATA_BITS samples -> STOP (or PARITY).
//   STOP:   after CLKS_PER_BIT cycles, sample.
//           1 -> LOAD. 0 -> framing_error<=1, byte discarded, -> IDLE.
//   LOAD:   one cycle. rx_data<=shift_q, data_ready<=1.
//           If data_ready=1 and data_read=0 this cycle, overrun_error<=1; rx_data still overwritten.
//           Then -> IDLE.
//  Latency (defaults): stop sampled cycle 95, LOAD cycle 96, data_ready visible cycle 97.
//  data_read=1: data_ready<=0 and overrun_error<=0 next cycle.
//   data_read in the LOAD cycle: data_ready stays 1, no overrun.
//  Line held low after framing error: no new start until a 1->0 transition.
//  n_rst mid-frame: immediate return to reset values; partial byte lost.
//  Counter width $clog2(CLKS_PER_BIT). bit_idx width $clog2(DATA_BITS+1). No wrap beyond terminal count.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   PARITY state between DATA and STOP; one even-parity bit sampled.
//   Mismatch: parity_error<=1 at LOAD. Byte still loaded, data_ready still set.
//   parity_error clears on data_read.
//  UART_RX_PARITY_EN undefined: no PARITY state, no parity_error port; frame = start+data+stop.
// STRUCTURE
//  Package uart_rx_pkg:
//   typedef enum logic [2:0] rx_state_t {IDLE,START,DATA,PARITY,STOP,LOAD}.
//   localparam HALF_BIT = CLKS_PER_BIT/2.
//  Sub-module uart_rx_timer: bit-period counter.
//   Inputs clear, enable, half_sel. Outputs half_tick, bit_tick.
//  FSM, shift register and flags live in uart_rx_core.
// TESTING (CLKS_PER_BIT=10, DATA_BITS=8)
//  1 Frame 0xA5, stop 1 -> data_ready=1 at cycle 97, rx_data=8'hA5, no error flags.
//  2 Second frame 0x3C with no data_read -> rx_data=8'h3C, overrun_error=1.
//    Then data_read pulse -> data_ready=0, overrun_error=0.
//  3 Frame 0x55 with stop 0 -> framing_error=1, data_ready unchanged, rx_data keeps old value.
//  4 Low pulse of 3 cycles on an idle line -> returns to IDLE at cycle 5, no flags, no data.
//  5 n_rst asserted at cycle 40 of a frame -> all outputs 0.
//    Next full 0x81 frame received correctly.
//  6 data_read in the LOAD cycle of frame 0xFF -> data_ready=1, overrun_error=0.
//    With UART_RX_PARITY_EN, 0x07 + parity 0 -> parity_error=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive core.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD} rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int HALF_BIT         = DEF_CLKS_PER_BIT / 2;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// Bit-period counter: half_tick marks the start-bit centre, bit_tick a full bit period.
module uart_rx_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  input  logic half_sel,
  output logic half_tick,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HB = half_bit(CLKS_PER_BIT);

  logic [CW-1:0] cnt;
  logic          term;

  assign half_tick = (cnt == CW'(HB - 1));
  assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign term      = half_sel ? half_tick : bit_tick;

  // Restart from zero on the selected terminal count so the next period lines up.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (enable)  cnt <= term ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: start detect, mid-bit sampling, stop check, byte hand-off.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 framing_error
);

  localparam int IW = $clog2(DATA_BITS + 1);

  rx_state_t            state, state_n;
  logic                 prev_q, start_edge;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tmr_clear, tmr_en, half_sel, half_tick, bit_tick;
  logic                 shift_en, stop_bad, load, last_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_en, par_q;
`endif

  assign start_edge = prev_q & ~serial_in;
  assign last_bit   = (bit_idx == IW'(DATA_BITS - 1));

  uart_rx_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (tmr_clear),
    .enable    (tmr_en),
    .half_sel  (half_sel),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    half_sel  = 1'b0;
    shift_en  = 1'b0;
    stop_bad  = 1'b0;
    load      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (start_edge) state_n = START;
      end
      START: begin
        tmr_en   = 1'b1;
        half_sel = 1'b1;
        // A line back high at the start-bit centre was only a glitch.
        if (half_tick) state_n = serial_in ? IDLE : DATA;
      end
      DATA: begin
        tmr_en = 1'b1;
        if (bit_tick) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (last_bit) state_n = PARITY;
`else
          if (last_bit) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        tmr_en = 1'b1;
        if (bit_tick) begin
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        tmr_en = 1'b1;
        if (bit_tick) begin
          if (serial_in) state_n = LOAD;
          else begin
            stop_bad = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q        <= 1'b1;
      bit_idx       <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      prev_q <= serial_in;
      if (state == IDLE)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift_q <= {serial_in, shift_q[DATA_BITS-1:1]};
      if (state == IDLE && start_edge) framing_error <= 1'b0;
      else if (stop_bad)               framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_en) par_q <= serial_in;
`endif
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_error  <= 1'b0;
`endif
      end
      // A load wins over a simultaneous read, and a read in that cycle avoids overrun.
      if (load) begin
        rx_data    <= shift_q;
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_error <= par_q ^ (^shift_q);
`endif
      end
    end
  end

endmodule
